dmi_initiator: RTL and testbench

//  DMI master (DTM side): takes single read/write commands from a host port, issues one dm::dmi_req_t per command
//  to the debug module's DMI slave port, and returns the response data plus a status to the host.

---
 rtl/dm_pkg.sv | 51 +++++
 rtl/dmi_initiator_timer.sv | 38 +++
 rtl/dmi_initiator.sv | 162 ++++++++++++++++
 tb/tb_dmi_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Debug-module DMI types shared by the DTM-side initiator and its timer.
// Holds the DMI request/response structs plus the initiator status and state encodings.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        DmiInitOk      = 2'd0,
        DmiInitErr     = 2'd1,
        DmiInitBusy    = 2'd2,
        DmiInitTimeout = 2'd3
    } dmi_init_status_e;

    typedef enum logic [1:0] {
        Idle,
        Req,
        WaitRsp,
        HostRsp
    } dmi_init_state_e;

    localparam logic [1:0] DmiRespOk   = 2'd0;
    localparam logic [1:0] DmiRespErr  = 2'd2;
    localparam logic [1:0] DmiRespBusy = 2'd3;

    // The reserved code 1 has no defined meaning on the slave side, so it is reported as an error.
    function automatic dmi_init_status_e map_resp(input logic [1:0] resp);
        dmi_init_status_e status;
        unique case (resp)
            DmiRespOk:   status = DmiInitOk;
            DmiRespBusy: status = DmiInitBusy;
            default:     status = DmiInitErr;
        endcase
        return status;
    endfunction

endpackage

// File: rtl/dmi_initiator_timer.sv
// Response timeout counter for the DMI initiator: clear/enable counter with a one-cycle expire pulse.
// expire_o fires in the cycle the count reaches TimeoutCycles-1 while enabled.
module dmi_init_timer #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clear_i && (cnt_q == LastCnt);

endmodule

// File: rtl/dmi_initiator.sv
// DTM-side DMI master: one host read/write command becomes one DMI request, and the response returns to the host.
// Optional macro DMI_BUSY_RETRY_EN re-issues BUSY-answered requests up to MaxRetries times.
module dmi_initiator
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned MaxRetries    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [6:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_status_o,
    output logic        stray_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [40:0] dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [33:0] dmi_resp_i
);

    dmi_init_state_e  state_q, state_d;
    dmi_req_t         req_q, req_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    dmi_init_status_e rsp_status_q, rsp_status_d;
    logic             stray_q, stray_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_valid_q, req_valid_d;
    logic             resp_ready_q, resp_ready_d;
    logic             timer_clear;
    logic             timer_expire;
    dmi_resp_t        resp;

    assign resp = dmi_resp_t'(dmi_resp_i);

`ifdef DMI_BUSY_RETRY_EN
    localparam int unsigned RetryW = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetries);
    logic [RetryW-1:0] retry_q, retry_d;
`endif

    dmi_init_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (timer_clear),
        .en_i    (state_q == WaitRsp),
        .expire_o(timer_expire)
    );

    // Handshake outputs are registered from the next state, so every output is clean out of reset.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        stray_d      = stray_q;
        timer_clear  = 1'b0;
`ifdef DMI_BUSY_RETRY_EN
        retry_d      = retry_q;
`endif
        unique case (state_q)
            Idle: begin
`ifdef DMI_BUSY_RETRY_EN
                retry_d = '0;
`endif
                if (dmi_resp_valid_i && resp_ready_q) begin
                    stray_d = 1'b1;
                end
                if (cmd_valid_i && cmd_ready_q) begin
                    req_d.addr = cmd_addr_i;
                    req_d.op   = cmd_write_i ? DTM_WRITE : DTM_READ;
                    req_d.data = cmd_data_i;
                    state_d    = Req;
                end
            end
            Req: begin
                if (dmi_req_ready_i && req_valid_q) begin
                    timer_clear = 1'b1;
                    state_d     = WaitRsp;
                end
            end
            WaitRsp: begin
                if (dmi_resp_valid_i && resp_ready_q) begin
                    rsp_data_d   = resp.data;
                    rsp_status_d = map_resp(resp.resp);
                    state_d      = HostRsp;
`ifdef DMI_BUSY_RETRY_EN
                    if (resp.resp == DmiRespBusy && retry_q < RetryMax) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = Req;
                    end
`endif
                end else if (timer_expire) begin
                    rsp_data_d   = '0;
                    rsp_status_d = DmiInitTimeout;
                    state_d      = HostRsp;
                end
            end
            HostRsp: begin
                if (rsp_ready_i && rsp_valid_q) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase

        cmd_ready_d  = (state_d == Idle);
        req_valid_d  = (state_d == Req);
        resp_ready_d = (state_d == Idle) || (state_d == WaitRsp);
        rsp_valid_d  = (state_d == HostRsp);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= Idle;
            req_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= DmiInitOk;
            stray_q      <= 1'b0;
            cmd_ready_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
`ifdef DMI_BUSY_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            stray_q      <= stray_d;
            cmd_ready_q  <= cmd_ready_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            rsp_valid_q  <= rsp_valid_d;
`ifdef DMI_BUSY_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign cmd_ready_o      = cmd_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_status_o     = rsp_status_q;
    assign stray_o          = stray_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dmi_initiator.sv
// Scoreboard bench for dmi_initiator: directed host commands with a scripted DMI slave.
// A negedge monitor pops expected host responses; the stimulus thread checks handshakes and timing.
module tb_dmi_initiator;
    import dm::*;

    localparam int unsigned TimeoutCycles = 8;
    localparam int unsigned MaxRetries    = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [6:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_status_o;
    logic        stray_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [40:0] dmi_req_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [33:0] dmi_resp_i;

    dmi_initiator #(
        .TimeoutCycles(TimeoutCycles),
        .MaxRetries   (MaxRetries)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_write_i     (cmd_write_i),
        .cmd_addr_i      (cmd_addr_i),
        .cmd_data_i      (cmd_data_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_data_o      (rsp_data_o),
        .rsp_status_o    (rsp_status_o),
        .stray_o         (stray_o),
        .dmi_req_valid_o (dmi_req_valid_o),
        .dmi_req_ready_i (dmi_req_ready_i),
        .dmi_req_o       (dmi_req_o),
        .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_i      (dmi_resp_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  status;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   hs_count   = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Host-side monitor: every accepted host response must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rsp: got data=0x%0h status=%0d, required no response",
                         rsp_data_o, rsp_status_o);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("rsp_data", 64'(rsp_data_o), 64'(mon_e.data));
                check_output("rsp_status", 64'(rsp_status_o), 64'(mon_e.status));
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && dmi_req_valid_o && dmi_req_ready_i) hs_count++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [6:0] addr, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready_o && n < 100) begin
            tick();
            n++;
        end
        check_output("cmd_ready_wait", 64'(cmd_ready_o), 64'(1));
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic slave_accept(input int delay, output logic [40:0] req);
        int   n      = 0;
        logic stable = 1'b1;
        while (!dmi_req_valid_o && n < 100) begin
            tick();
            n++;
        end
        check_output("req_valid_wait", 64'(dmi_req_valid_o), 64'(1));
        req = dmi_req_o;
        for (int i = 0; i < delay; i++) begin
            tick();
            if (dmi_req_o !== req || dmi_req_valid_o !== 1'b1) stable = 1'b0;
        end
        if (delay > 0) check_output("req_stable", 64'(stable), 64'(1));
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
    endtask

    task automatic slave_respond(input int delay, input logic [1:0] code, input logic [31:0] data);
        logic rdy;
        int   n = 0;
        repeat (delay) tick();
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = {data, code};
        do begin
            rdy = dmi_resp_ready_o;
            tick();
            n++;
        end while (!rdy && n < 100);
        check_output("resp_accept_wait", 64'(rdy), 64'(1));
        dmi_resp_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check_output("rsp_drain", 64'(exp_q.size()), 64'(0));
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [40:0] req;
        int          n;
        int          hs0;
        logic        ok;

        rst_i            = 1'b1;
        cmd_valid_i      = 1'b0;
        cmd_write_i      = 1'b0;
        cmd_addr_i       = '0;
        cmd_data_i       = '0;
        rsp_ready_i      = 1'b1;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;

        // Reset values: everything low except dmi_resp_ready_o.
        #2;
        check_output("reset_ctrl", 64'({cmd_ready_o, rsp_valid_o, dmi_req_valid_o, dmi_resp_ready_o, stray_o}),
                     64'(5'b00010));
        check_output("reset_req", 64'(dmi_req_o), 64'(0));
        check_output("reset_rsp", 64'({rsp_data_o, rsp_status_o}), 64'(0));
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();
        tick();
        check_output("idle_cmd_ready", 64'(cmd_ready_o), 64'(1));

        // Write 0x1 to 0x10, immediate ready, OK two cycles later.
        exp_q.push_back('{data: 32'h0, status: 2'd0});
        apply_stimulus(1'b1, 7'h10, 32'h1);
        slave_accept(0, req);
        check_output("write_req", 64'(req), 64'({7'h10, 2'd2, 32'h1}));
        slave_respond(2, 2'd0, 32'h0);
        wait_drain();

        // Read 0x04 with a five-cycle slave stall.
        exp_q.push_back('{data: 32'hDEADBEEF, status: 2'd0});
        apply_stimulus(1'b0, 7'h04, 32'h0);
        slave_accept(5, req);
        check_output("read_req", 64'(req), 64'({7'h04, 2'd1, 32'h0}));
        slave_respond(1, 2'd0, 32'hDEADBEEF);
        wait_drain();

        // Error response.
        exp_q.push_back('{data: 32'h12345678, status: 2'd1});
        apply_stimulus(1'b0, 7'h05, 32'h0);
        slave_accept(0, req);
        slave_respond(1, 2'd2, 32'h12345678);
        wait_drain();

        // No response: TIMEOUT exactly TimeoutCycles after the request handshake.
        exp_q.push_back('{data: 32'h0, status: 2'd3});
        apply_stimulus(1'b0, 7'h06, 32'h0);
        slave_accept(0, req);
        n = 0;
        while (!rsp_valid_o && n < 50) begin
            tick();
            n++;
        end
        check_output("timeout_latency", 64'(n), 64'(8));
        wait_drain();

        // Response in the expiry cycle wins over the timeout.
        exp_q.push_back('{data: 32'h0000CAFE, status: 2'd0});
        apply_stimulus(1'b0, 7'h07, 32'h0);
        slave_accept(0, req);
        slave_respond(7, 2'd0, 32'h0000CAFE);
        wait_drain();

        // BUSY handling.
        hs0 = hs_count;
`ifdef DMI_BUSY_RETRY_EN
        exp_q.push_back('{data: 32'h77, status: 2'd0});
        apply_stimulus(1'b0, 7'h16, 32'h0);
        for (int i = 0; i < 3; i++) begin
            slave_accept(0, req);
            check_output("retry_req", 64'(req), 64'({7'h16, 2'd1, 32'h0}));
            slave_respond(1, 2'd3, 32'hBB);
        end
        slave_accept(0, req);
        slave_respond(1, 2'd0, 32'h77);
        wait_drain();
        check_output("busy_handshakes", 64'(hs_count - hs0), 64'(4));
`else
        exp_q.push_back('{data: 32'hBB, status: 2'd2});
        apply_stimulus(1'b0, 7'h16, 32'h0);
        slave_accept(0, req);
        slave_respond(1, 2'd3, 32'hBB);
        wait_drain();
        check_output("busy_handshakes", 64'(hs_count - hs0), 64'(1));
`endif

        // Host back-pressure: new command and a late DMI response are both held off.
        rsp_ready_i = 1'b0;
        exp_q.push_back('{data: 32'h55, status: 2'd0});
        apply_stimulus(1'b0, 7'h08, 32'h0);
        slave_accept(0, req);
        slave_respond(1, 2'd0, 32'h55);
        n = 0;
        while (!rsp_valid_o && n < 50) begin
            tick();
            n++;
        end
        check_output("holdoff_valid", 64'(rsp_valid_o), 64'(1));
        cmd_valid_i      = 1'b1;
        cmd_write_i      = 1'b1;
        cmd_addr_i       = 7'h11;
        cmd_data_i       = 32'hA5A5A5A5;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = {32'h99, 2'd0};
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_ready_o || !rsp_valid_o || dmi_resp_ready_o) ok = 1'b0;
        end
        check_output("holdoff_blocked", 64'(ok), 64'(1));
        dmi_resp_valid_i = 1'b0;
        check_output("holdoff_no_stray", 64'(stray_o), 64'(0));
        exp_q.push_back('{data: 32'h0, status: 2'd0});
        rsp_ready_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cmd_ready_o && n < 50);
        check_output("holdoff_rsp_done", 64'(rsp_valid_o), 64'(0));
        tick();
        cmd_valid_i = 1'b0;
        slave_accept(0, req);
        check_output("queued_cmd_req", 64'(req), 64'({7'h11, 2'd2, 32'hA5A5A5A5}));
        slave_respond(0, 2'd0, 32'h0);
        wait_drain();

        // Reset while waiting for the response, then a response arrives in IDLE.
        apply_stimulus(1'b0, 7'h20, 32'h0);
        slave_accept(0, req);
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        check_output("midrst_ctrl", 64'({cmd_ready_o, rsp_valid_o, dmi_req_valid_o, dmi_resp_ready_o, stray_o}),
                     64'(5'b00010));
        check_output("midrst_req", 64'(dmi_req_o), 64'(0));
        tick();
        rst_i = 1'b0;
        tick();
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = {32'h77, 2'd0};
        tick();
        dmi_resp_valid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid_o) ok = 1'b1;
        end
        check_output("stray_set", 64'(stray_o), 64'(1));
        check_output("no_rsp_after_reset", 64'(ok), 64'(0));
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
